// File: rtl/keypad_entry_if.sv
// Keypad entry bus: key strobe and code in, digit count in, action pulses and BCD entry out.
interface keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [2:0]  digit_count;
  logic        increment_counter_pulse;
  logic        restart_pulse;
  logic        enter_pulse;
  logic [15:0] entry_code;

  modport master (
    output key_valid,
    output key_code,
    output digit_count,
    input  increment_counter_pulse,
    input  restart_pulse,
    input  enter_pulse,
    input  entry_code
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  digit_count,
    output increment_counter_pulse,
    output restart_pulse,
    output enter_pulse,
    output entry_code
  );
endinterface

// File: rtl/keypad_entry.sv
// Keypad front end: synchronise, debounce and classify key strobes into counter pulses and a
// 4-digit BCD entry. Optional idle auto-clear is built when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input logic           clk,
  input logic           sys_reset,
  keypad_entry_if.slave kp
);

  typedef enum logic [1:0] {StIdle, StDebounce, StAccept, StWaitRelease} state_e;

  localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        sync1_q, kv_s_q;
  logic [7:0]  db_cnt_q, db_cnt_d;
  logic [3:0]  kc_q, kc_d;
  logic [15:0] entry_q, entry_d;
  logic        inc_q, inc_d;
  logic        restart_q, restart_d;
  logic        enter_q, enter_d;
  logic        timeout;

`ifdef KEYPAD_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  // Counts consecutive IDLE cycles with digits held; any other state restarts it.
  always_comb begin
    timeout    = 1'b0;
    idle_cnt_d = 32'd0;
    if (state_q == StIdle && kp.digit_count != 3'd0) begin
      if (idle_cnt_q == TIMEOUT_CYCLES - 1) begin
        timeout = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      idle_cnt_q <= 32'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q   <= StIdle;
      sync1_q   <= 1'b0;
      kv_s_q    <= 1'b0;
      db_cnt_q  <= 8'd0;
      kc_q      <= 4'h0;
      entry_q   <= 16'h0000;
      inc_q     <= 1'b0;
      restart_q <= 1'b0;
      enter_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= kp.key_valid;
      kv_s_q    <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      kc_q      <= kc_d;
      entry_q   <= entry_d;
      inc_q     <= inc_d;
      restart_q <= restart_d;
      enter_q   <= enter_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    kc_d     = kc_q;
    unique case (state_q)
      StIdle: begin
        if (kv_s_q) begin
          kc_d     = kp.key_code;
          db_cnt_d = 8'd0;
          state_d  = StDebounce;
        end
      end
      StDebounce: begin
        if (!kv_s_q) begin
          state_d = StIdle;
        end else if (kp.key_code != kc_q) begin
          // Code moved under a held strobe: restart the stability window on the new code.
          kc_d     = kp.key_code;
          db_cnt_d = 8'd0;
        end else if (db_cnt_q == DbLast) begin
          state_d = StAccept;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      StAccept: begin
        db_cnt_d = 8'd0;
        state_d  = StWaitRelease;
      end
      StWaitRelease: begin
        if (kv_s_q) begin
          db_cnt_d = 8'd0;
        end else if (db_cnt_q == DbLast) begin
          state_d = StIdle;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    entry_d   = entry_q;
    inc_d     = 1'b0;
    restart_d = 1'b0;
    enter_d   = 1'b0;
    if (state_q == StAccept) begin
      if (kc_q <= 4'h9) begin
        if (kp.digit_count < 3'd4) begin
          entry_d = {entry_q[11:0], kc_q};
          inc_d   = 1'b1;
        end
      end else if (kc_q == 4'hA) begin
        entry_d   = 16'h0000;
        restart_d = 1'b1;
      end else if (kc_q == 4'hB) begin
        // Enter with a short code behaves as clear.
        if (kp.digit_count == 3'd4) begin
          enter_d = 1'b1;
        end else begin
          entry_d   = 16'h0000;
          restart_d = 1'b1;
        end
      end
    end else if (timeout) begin
      entry_d   = 16'h0000;
      restart_d = 1'b1;
    end
  end

  assign kp.increment_counter_pulse = inc_q;
  assign kp.restart_pulse           = restart_q;
  assign kp.enter_pulse             = enter_q;
  assign kp.entry_code              = entry_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: an event-schedule model predicts every pulse and entry value.
module tb_keypad_entry;

  localparam int unsigned Deb = 4;
  localparam int unsigned Tmo = 50;

  typedef struct {
    int         at;
    logic [3:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic sys_reset;
  int   cyc = 0;

  keypad_entry_if kp ();

  keypad_entry #(
    .DEBOUNCE_CYCLES(Deb),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk      (clk),
    .sys_reset(sys_reset),
    .kp       (kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  ev_t         evq[$];
  ev_t         ev;
  int          to_at = -1;
  int          dc = 0;
  logic [15:0] exp_entry = 16'h0000;
  logic        e_inc, e_rst, e_ent;
  int          n_inc = 0, n_rst = 0, n_ent = 0, first_inc = -1;
  int          last_n, last_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // A clean press: accepted action lands in the cycle after edge N+Deb+3.
  task automatic press(input logic [3:0] code, input int hold, input int rel);
    ev_t e;
    @(negedge clk);
    kp.key_code  = code;
    kp.key_valid = 1'b1;
    last_n = cyc + 1;
    e.at   = last_n + Deb + 3;
    e.code = code;
    evq.push_back(e);
    repeat (hold) @(negedge clk);
    kp.key_valid = 1'b0;
    last_r = cyc + 1;
    repeat (rel) @(negedge clk);
  endtask

  // Model, digit-counter stand-in and per-cycle compare.
  initial begin
    kp.digit_count = 3'd0;
    forever begin
      @(posedge clk);
      #2;
      e_inc = 1'b0;
      e_rst = 1'b0;
      e_ent = 1'b0;
      if (sys_reset) begin
        exp_entry = 16'h0000;
        dc = 0;
        to_at = -1;
        evq.delete();
      end else begin
        if (evq.size() > 0 && evq[0].at == cyc) begin
          ev = evq.pop_front();
          if (ev.code <= 4'h9) begin
            if (dc < 4) begin
              exp_entry = {exp_entry[11:0], ev.code};
              e_inc = 1'b1;
              dc++;
            end
          end else if (ev.code == 4'hA || (ev.code == 4'hB && dc != 4)) begin
            exp_entry = 16'h0000;
            e_rst = 1'b1;
            dc = 0;
          end else if (ev.code == 4'hB) begin
            e_ent = 1'b1;
          end
        end
        if (cyc == to_at) begin
          exp_entry = 16'h0000;
          e_rst = 1'b1;
          dc = 0;
          to_at = -1;
        end
      end
      chk("increment_counter_pulse", 32'(kp.increment_counter_pulse), 32'(e_inc));
      chk("restart_pulse", 32'(kp.restart_pulse), 32'(e_rst));
      chk("enter_pulse", 32'(kp.enter_pulse), 32'(e_ent));
      chk("entry_code", 32'(kp.entry_code), 32'(exp_entry));
      if (kp.increment_counter_pulse === 1'b1) begin
        n_inc++;
        if (first_inc < 0) first_inc = cyc;
      end
      if (kp.restart_pulse === 1'b1) n_rst++;
      if (kp.enter_pulse === 1'b1) n_ent++;
      kp.digit_count = 3'(dc);
    end
  end

  initial begin
    sys_reset    = 1'b1;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_entry", 32'(kp.entry_code), 32'h0);
    sys_reset = 1'b0;

    // Single digit: latency and value.
    press(4'h5, 20, 10);
    chk("t1_latency", 32'(first_inc), 32'(last_n + 7));
    chk("t1_entry", 32'(kp.entry_code), 32'h0005);
    chk("t1_model", 32'(exp_entry), 32'h0005);

    // Clear, four digits, then a fifth digit that must be ignored.
    press(4'hA, 10, 10);
    for (int k = 1; k <= 4; k++) press(4'(k), 10, 10);
    chk("t2_entry", 32'(kp.entry_code), 32'h1234);
    chk("t2_model", 32'(exp_entry), 32'h1234);
    press(4'h9, 10, 10);
    chk("t2_fifth_ignored", 32'(kp.entry_code), 32'h1234);
    chk("t2_inc_count", 32'(n_inc), 32'd5);

    // Enter with four digits, clear, then enter with two digits acts as clear.
    press(4'hB, 10, 10);
    chk("t4_enter_count", 32'(n_ent), 32'd1);
    chk("t4_enter_holds", 32'(kp.entry_code), 32'h1234);
    press(4'hA, 10, 10);
    chk("t4_clear_entry", 32'(kp.entry_code), 32'h0000);
    chk("t4_restart_count", 32'(n_rst), 32'd2);
    press(4'h6, 10, 10);
    press(4'h7, 10, 10);
    chk("t4_two_digits", 32'(kp.entry_code), 32'h0067);
    press(4'hB, 10, 10);
    chk("t4_short_enter", 32'(n_rst), 32'd3);
    chk("t4_enter_unchanged", 32'(n_ent), 32'd1);
    chk("t4_short_entry", 32'(kp.entry_code), 32'h0000);

    // Two-cycle glitch must be rejected.
    @(negedge clk);
    kp.key_code  = 4'h3;
    kp.key_valid = 1'b1;
    repeat (2) @(negedge clk);
    kp.key_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_glitch", 32'(n_inc), 32'd7);

    // Release bounce must not produce a second action.
    press(4'h8, 12, 0);
    repeat (2) @(negedge clk);
    kp.key_valid = 1'b1;
    @(negedge clk);
    kp.key_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("t3_bounce", 32'(n_inc), 32'd8);
    chk("t3_entry", 32'(kp.entry_code), 32'h0008);

    // Reset during debounce abandons the key.
    @(negedge clk);
    kp.key_code  = 4'h7;
    kp.key_valid = 1'b1;
    repeat (4) @(negedge clk);
    sys_reset    = 1'b1;
    kp.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    sys_reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_reset_entry", 32'(kp.entry_code), 32'h0000);
    chk("t5_no_pulse", 32'(n_inc), 32'd8);
    press(4'h7, 10, 0);
    chk("t5_entry", 32'(kp.entry_code), 32'h0007);
    chk("t5_inc_count", 32'(n_inc), 32'd9);

    // Idle after one held digit: auto-clear only when the timeout is built.
`ifdef KEYPAD_TIMEOUT_EN
    to_at = last_r + Deb + 1 + Tmo;
`endif
    repeat (70) @(negedge clk);
`ifdef KEYPAD_TIMEOUT_EN
    chk("t6_timeout_restart", 32'(n_rst), 32'd4);
    chk("t6_timeout_entry", 32'(kp.entry_code), 32'h0000);
`else
    chk("t6_no_timeout", 32'(n_rst), 32'd3);
    chk("t6_entry_held", 32'(kp.entry_code), 32'h0007);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
